// File: rtl/druaga_bg_linefetch_if.sv
// Bundle of the fetcher's control, VRAM, char-ROM and display-read signals.
// The master side is the surrounding video block; the slave side is the fetcher.
interface druaga_bg_linefetch_if #(
  parameter int unsigned COLS_LOG2 = 6,
  parameter int unsigned ROWS_LOG2 = 6,
  parameter int unsigned BPP       = 2,
  parameter int unsigned PAL_W     = 6
);
  logic                           line_start;
  logic [8:0]                     vline;
  logic [8:0]                     scroll;
  logic                           flip;
  logic [COLS_LOG2+ROWS_LOG2-1:0] vram_a;
  logic [15:0]                    vram_d;
  logic                           chr_req;
  logic [10:0]                    chr_a;
  logic                           chr_ack;
  logic [8*BPP-1:0]               chr_d;
  logic [8:0]                     pix_x;
  logic [PAL_W+BPP-1:0]           pix_out;
  logic                           pix_pri;
  logic                           busy;
  logic                           overrun;

  modport master (
    output line_start, vline, scroll, flip, vram_d, chr_ack, chr_d, pix_x,
    input  vram_a, chr_req, chr_a, pix_out, pix_pri, busy, overrun
  );

  modport slave (
    input  line_start, vline, scroll, flip, vram_d, chr_ack, chr_d, pix_x,
    output vram_a, chr_req, chr_a, pix_out, pix_pri, busy, overrun
  );
endinterface

// File: rtl/druaga_bg_linefetch.sv
// BG scanline fetcher: walks the tilemap for the next line, expands char rows into one bank
// of a double-buffered line buffer while the display side reads the other bank.
module druaga_bg_linefetch #(
  parameter int unsigned LINE_W    = 288,
  parameter int unsigned COLS_LOG2 = 6,
  parameter int unsigned ROWS_LOG2 = 6,
  parameter int unsigned BPP       = 2,
  parameter int unsigned PAL_W     = 6
) (
  input logic                  vclkx8_i,
  input logic                  reset_i,
  druaga_bg_linefetch_if.slave bus_io
);
  localparam int unsigned NumTiles = LINE_W / 8 + 1;
  localparam int unsigned TileW    = $clog2(NumTiles);
  localparam int unsigned EntW     = 1 + PAL_W + BPP;
  localparam int unsigned Depth    = 2 * LINE_W;
  localparam int unsigned AddrW    = $clog2(Depth);

  typedef enum logic [2:0] {StIdle, StMap, StLatch, StChr, StWr, StDone} state_e;

  state_e               state_q, state_d;
  logic                 disp_bank_q, disp_bank_d;
  logic [1:0]           valid_q, valid_d;
  logic [8:0]           vline_q, vline_d;
  logic [8:0]           scroll_q, scroll_d;
  logic                 flip_q, flip_d;
  logic [TileW-1:0]     tile_q, tile_d;
  logic [2:0]           pix_q, pix_d;
  logic [7:0]           code_q, code_d;
  logic [PAL_W-1:0]     pal_q, pal_d;
  logic                 pri_q, pri_d;
  logic [8*BPP-1:0]     row_q, row_d;
  logic                 overrun_q, overrun_d;
  logic [PAL_W+BPP-1:0] pix_out_q;
  logic                 pix_pri_q;

  logic [EntW-1:0]      mem_q [Depth];
  logic                 wr_en;
  logic [AddrW-1:0]     wr_idx, rd_idx;
  logic [EntW-1:0]      wr_ent, rd_ent;
  logic [11:0]          x_raw, x_st;
  logic                 x_ok, rd_ok;
  logic [2:0]           pix_rev;
  logic [COLS_LOG2-1:0] col;
  logic [ROWS_LOG2-1:0] row;
  logic                 unused_vram_d;

  assign unused_vram_d = bus_io.vram_d[15];

  assign col = COLS_LOG2'(scroll_q[8:3]) + COLS_LOG2'(tile_q);
  assign row = ROWS_LOG2'(vline_q[8:3]);

  // Destination X of the current pixel; bit 11 set means it fell left of the line.
  assign x_raw   = 12'({tile_q, pix_q}) - 12'(scroll_q[2:0]);
  assign x_ok    = !x_raw[11] && (x_raw < 12'(LINE_W));
  assign x_st    = flip_q ? (12'(LINE_W - 1) - x_raw) : x_raw;
  assign pix_rev = 3'd7 - pix_q;
  assign wr_ent  = {pri_q, pal_q, row_q[pix_rev*BPP +: BPP]};
  // The fetch bank is always the one not being displayed.
  assign wr_idx  = AddrW'(x_st) + (disp_bank_q ? AddrW'(0) : AddrW'(LINE_W));

  assign rd_idx  = AddrW'(bus_io.pix_x) + (disp_bank_q ? AddrW'(LINE_W) : AddrW'(0));
  assign rd_ok   = (12'(bus_io.pix_x) < 12'(LINE_W)) && valid_q[disp_bank_q];
  assign rd_ent  = mem_q[rd_idx];

  assign bus_io.vram_a  = {row, col};
  assign bus_io.chr_a   = {code_q, vline_q[2:0]};
  assign bus_io.chr_req = (state_q == StChr) && !bus_io.line_start;
  assign bus_io.busy    = (state_q != StIdle);
  assign bus_io.overrun = overrun_q;
  assign bus_io.pix_out = pix_out_q;
  assign bus_io.pix_pri = pix_pri_q;

  always_comb begin
    state_d     = state_q;
    disp_bank_d = disp_bank_q;
    valid_d     = valid_q;
    vline_d     = vline_q;
    scroll_d    = scroll_q;
    flip_d      = flip_q;
    tile_d      = tile_q;
    pix_d       = pix_q;
    code_d      = code_q;
    pal_d       = pal_q;
    pri_d       = pri_q;
    row_d       = row_q;
    overrun_d   = 1'b0;
    wr_en       = 1'b0;

    if (bus_io.line_start) begin
      // Swap unconditionally; an aborted fetch leaves its bank invalid for display.
      overrun_d            = (state_q != StIdle);
      disp_bank_d          = ~disp_bank_q;
      valid_d[disp_bank_q] = 1'b0;
      vline_d              = bus_io.vline;
      scroll_d             = bus_io.scroll;
      flip_d               = bus_io.flip;
      tile_d               = '0;
      state_d              = StMap;
    end else begin
      unique case (state_q)
        StIdle: ;
        StMap:  state_d = StLatch;
        StLatch: begin
          code_d  = bus_io.vram_d[7:0];
          pal_d   = bus_io.vram_d[8 +: PAL_W];
          pri_d   = bus_io.vram_d[14];
          state_d = StChr;
        end
        StChr: begin
          if (bus_io.chr_ack) begin
            row_d   = bus_io.chr_d;
            pix_d   = 3'd0;
            state_d = StWr;
          end
        end
        StWr: begin
          wr_en = x_ok;
          pix_d = pix_q + 3'd1;
          if (pix_q == 3'd7) begin
            if (tile_q == TileW'(NumTiles - 1)) begin
              state_d = StDone;
            end else begin
              tile_d  = tile_q + TileW'(1);
              state_d = StMap;
            end
          end
        end
        StDone: begin
          valid_d[~disp_bank_q] = 1'b1;
          state_d               = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge vclkx8_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      disp_bank_q <= 1'b0;
      valid_q     <= 2'b00;
      vline_q     <= '0;
      scroll_q    <= '0;
      flip_q      <= 1'b0;
      tile_q      <= '0;
      pix_q       <= '0;
      code_q      <= '0;
      pal_q       <= '0;
      pri_q       <= 1'b0;
      row_q       <= '0;
      overrun_q   <= 1'b0;
      pix_out_q   <= '0;
      pix_pri_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_bank_q <= disp_bank_d;
      valid_q     <= valid_d;
      vline_q     <= vline_d;
      scroll_q    <= scroll_d;
      flip_q      <= flip_d;
      tile_q      <= tile_d;
      pix_q       <= pix_d;
      code_q      <= code_d;
      pal_q       <= pal_d;
      pri_q       <= pri_d;
      row_q       <= row_d;
      overrun_q   <= overrun_d;
      pix_out_q   <= rd_ok ? rd_ent[PAL_W+BPP-1:0] : '0;
      pix_pri_q   <= rd_ok ? rd_ent[EntW-1] : 1'b0;
    end
  end

  always_ff @(posedge vclkx8_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_ent;
    end
  end
endmodule

// File: tb/tb_druaga_bg_linefetch.sv
// Randomised bench for the BG line fetcher, checked against a per-pixel tilemap/char-ROM model.
module tb_druaga_bg_linefetch;
  localparam int L = 288;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  druaga_bg_linefetch_if #(.COLS_LOG2(6), .ROWS_LOG2(6), .BPP(2), .PAL_W(6)) bus ();

  druaga_bg_linefetch #(
    .LINE_W(L), .COLS_LOG2(6), .ROWS_LOG2(6), .BPP(2), .PAL_W(6)
  ) dut (
    .vclkx8_i(clk),
    .reset_i (rst),
    .bus_io  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] vram_mem [4096];
  logic [15:0] chr_rom  [2048];
  logic [7:0]  rd_pix  [L];
  logic        rd_pri  [L];
  logic [7:0]  exp_pix [L];
  logic        exp_pri [L];

  int ack_lat = 1;
  bit ack_en  = 1'b1;
  int ack_cnt = 0;

  // Tilemap RAM: data valid one cycle after the address.
  always @(posedge clk) bus.vram_d <= vram_mem[bus.vram_a];

  // Char ROM responder: acks after ack_lat waiting cycles, one-cycle ack pulse.
  always @(negedge clk) begin
    if (rst) begin
      bus.chr_ack = 1'b0;
      bus.chr_d   = '0;
      ack_cnt     = 0;
    end else if (bus.chr_ack) begin
      bus.chr_ack = 1'b0;
    end else if (bus.chr_req && ack_en) begin
      if (ack_cnt >= ack_lat) begin
        bus.chr_ack = 1'b1;
        bus.chr_d   = chr_rom[bus.chr_a];
        ack_cnt     = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic fill_const(input logic [15:0] vw, input logic [15:0] cw);
    for (int i = 0; i < 4096; i++) vram_mem[i] = vw;
    for (int i = 0; i < 2048; i++) chr_rom[i] = cw;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) vram_mem[i] = 16'($urandom);
    for (int i = 0; i < 2048; i++) chr_rom[i] = 16'($urandom);
  endtask

  task automatic start_line(input logic [8:0] vl, input logic [8:0] sc, input logic fl);
    @(negedge clk);
    bus.vline = vl; bus.scroll = sc; bus.flip = fl; bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_line();
    for (int x = 0; x <= L; x++) begin
      @(negedge clk);
      if (x > 0) begin
        rd_pix[x-1] = bus.pix_out;
        rd_pri[x-1] = bus.pix_pri;
      end
      if (x < L) bus.pix_x = 9'(x);
    end
  endtask

  // Expected display line from the tilemap/char-ROM rules, independent of fetch order.
  task automatic model_line(input logic [8:0] vl, input logic [8:0] sc, input logic fl);
    int xs, s, t, p;
    logic [5:0]  col;
    logic [11:0] va;
    logic [10:0] ca;
    logic [15:0] w, c;
    for (int x = 0; x < L; x++) begin
      xs  = fl ? L - 1 - x : x;
      s   = xs + int'(sc[2:0]);
      t   = s / 8;
      p   = s % 8;
      col = 6'((int'(sc[8:3]) + t) % 64);
      va  = {vl[8:3], col};
      w   = vram_mem[va];
      ca  = {w[7:0], vl[2:0]};
      c   = chr_rom[ca];
      exp_pix[x] = {w[13:8], c[(7-p)*2 +: 2]};
      exp_pri[x] = w[14];
    end
  endtask

  // Fetch a line, swap it to display, read it back, and let the follow-on fetch finish.
  task automatic show_line(input logic [8:0] vl, input logic [8:0] sc, input logic fl,
                           output bit ok);
    bit ok1, ok2;
    start_line(vl, sc, fl);
    wait_idle(ok1);
    start_line(9'($urandom), 9'd0, 1'b0);
    read_line();
    wait_idle(ok2);
    ok = ok1 && ok2;
    model_line(vl, sc, fl);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.line_start = 1'b0; bus.vline = '0; bus.scroll = '0; bus.flip = 1'b0; bus.pix_x = '0;
    fill_const(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.overrun, bus.chr_req} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl busy/ovr/req=%b want 000", {bus.busy, bus.overrun, bus.chr_req});
    end
    n_checks++;
    if ({bus.vram_a, bus.chr_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_addr vram_a=%h chr_a=%h want 0", bus.vram_a, bus.chr_a);
    end
    read_line();
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== 8'h00 || rd_pri[x] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read x=%0d got %h/%b want 00/0", x, rd_pix[x], rd_pri[x]);
      end
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] want;
    fill_const(16'h4512, 16'h1B1B);
    ack_lat = 1;
    show_line(9'd16, 9'd0, 1'b0, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_busy_fall busy never dropped within bound");
    end
    for (int x = 0; x < 8; x++) begin
      want = {6'h05, 2'(x % 4)};
      n_checks++;
      if (rd_pix[x] !== want || rd_pri[x] !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_pix x=%0d got %h/%b want %h/1", x, rd_pix[x], rd_pri[x], want);
      end
    end
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== exp_pix[x] || rd_pri[x] !== exp_pri[x]) begin
        n_fail++;
        $display("FAIL basic_line x=%0d got %h/%b want %h/%b",
                 x, rd_pix[x], rd_pri[x], exp_pix[x], exp_pri[x]);
      end
    end
    // Out-of-range reads on a valid bank still return zero.
    @(negedge clk); bus.pix_x = 9'd288;
    @(negedge clk);
    n_checks++;
    if (bus.pix_out !== 8'h00 || bus.pix_pri !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_oob288 got %h/%b want 00/0", bus.pix_out, bus.pix_pri);
    end
    bus.pix_x = 9'd511;
    @(negedge clk);
    n_checks++;
    if (bus.pix_out !== 8'h00 || bus.pix_pri !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_oob511 got %h/%b want 00/0", bus.pix_out, bus.pix_pri);
    end
  endtask

  task automatic test_scroll();
    bit ok;
    logic [8:0] sc;
    for (int k = 0; k < 2; k++) begin
      fill_random();
      sc = (k == 0) ? 9'd3 : 9'h1F8;
      show_line(9'($urandom), sc, 1'b0, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL scroll_timeout scroll=%h", sc);
      end
      for (int x = 0; x < L; x++) begin
        n_checks++;
        if (rd_pix[x] !== exp_pix[x] || rd_pri[x] !== exp_pri[x]) begin
          n_fail++;
          $display("FAIL scroll_line sc=%h x=%0d got %h/%b want %h/%b",
                   sc, x, rd_pix[x], rd_pri[x], exp_pix[x], exp_pri[x]);
        end
      end
    end
  endtask

  task automatic test_flip();
    bit ok;
    logic [8:0] vl, sc;
    fill_random();
    vl = 9'($urandom);
    sc = 9'($urandom);
    ack_lat = 2;
    show_line(vl, sc, 1'b1, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL flip_timeout");
    end
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== exp_pix[x] || rd_pri[x] !== exp_pri[x]) begin
        n_fail++;
        $display("FAIL flip_line x=%0d got %h/%b want %h/%b",
                 x, rd_pix[x], rd_pri[x], exp_pix[x], exp_pri[x]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [8:0] vl, sc;
    logic fl;
    for (int k = 0; k < 5; k++) begin
      fill_random();
      vl = 9'($urandom); sc = 9'($urandom); fl = 1'($urandom);
      ack_lat = $urandom_range(0, 4);
      show_line(vl, sc, fl, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL random_timeout iter=%0d", k);
      end
      for (int x = 0; x < L; x++) begin
        n_checks++;
        if (rd_pix[x] !== exp_pix[x] || rd_pri[x] !== exp_pri[x]) begin
          n_fail++;
          $display("FAIL random_line it=%0d vl=%h sc=%h fl=%b x=%0d got %h/%b want %h/%b",
                   k, vl, sc, fl, x, rd_pix[x], rd_pri[x], exp_pix[x], exp_pri[x]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    bit ok, ok2;
    logic [8:0] sc;
    fill_random();
    ack_lat = 1;
    ack_en  = 1'b0;
    sc = 9'($urandom);
    start_line(9'd40, 9'd0, 1'b0);
    repeat (3000) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.chr_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_stall busy/req=%b%b want 11", bus.busy, bus.chr_req);
    end
    @(negedge clk);
    bus.vline = 9'd50; bus.scroll = sc; bus.flip = 1'b0; bus.line_start = 1'b1;
    #1;
    n_checks++;
    if (bus.chr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_req_drop chr_req=%b want 0", bus.chr_req);
    end
    @(negedge clk);
    bus.line_start = 1'b0;
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_pulse overrun=%b want 1", bus.overrun);
    end
    @(negedge clk);
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_pulse_len overrun=%b want 0", bus.overrun);
    end
    read_line();
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== 8'h00 || rd_pri[x] !== 1'b0) begin
        n_fail++;
        $display("FAIL ovr_blank x=%0d got %h/%b want 00/0", x, rd_pix[x], rd_pri[x]);
      end
    end
    ack_en = 1'b1;
    wait_idle(ok);
    start_line(9'd0, 9'd0, 1'b0);
    read_line();
    wait_idle(ok2);
    model_line(9'd50, sc, 1'b0);
    n_checks++;
    if (!(ok && ok2)) begin
      n_fail++;
      $display("FAIL ovr_recover_timeout");
    end
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== exp_pix[x] || rd_pri[x] !== exp_pri[x]) begin
        n_fail++;
        $display("FAIL ovr_recover x=%0d got %h/%b want %h/%b",
                 x, rd_pix[x], rd_pri[x], exp_pix[x], exp_pri[x]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    logic [8:0] vl;
    fill_random();
    ack_lat = 1;
    vl = 9'($urandom);
    bus.pix_x = 9'd10;
    start_line(9'($urandom), 9'd0, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.chr_req, bus.overrun, bus.pix_pri} !== 4'b0000 ||
        bus.pix_out !== 8'h00 || bus.vram_a !== 12'd0 || bus.chr_a !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs busy=%b req=%b ovr=%b pri=%b pix=%h va=%h ca=%h want all 0",
               bus.busy, bus.chr_req, bus.overrun, bus.pix_pri, bus.pix_out, bus.vram_a,
               bus.chr_a);
    end
    @(negedge clk);
    rst = 1'b0;
    read_line();
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== 8'h00 || rd_pri[x] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_bank0_blank x=%0d got %h/%b want 00/0", x, rd_pix[x], rd_pri[x]);
      end
    end
    start_line(vl, 9'd0, 1'b0);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart busy=%b want 1", bus.busy);
    end
    read_line();
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== 8'h00 || rd_pri[x] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_bank1_blank x=%0d got %h/%b want 00/0", x, rd_pix[x], rd_pri[x]);
      end
    end
    wait_idle(ok);
    start_line(9'd0, 9'd0, 1'b0);
    read_line();
    wait_idle(ok2);
    model_line(vl, 9'd0, 1'b0);
    n_checks++;
    if (!(ok && ok2)) begin
      n_fail++;
      $display("FAIL rst_refetch_timeout");
    end
    for (int x = 0; x < L; x++) begin
      n_checks++;
      if (rd_pix[x] !== exp_pix[x] || rd_pri[x] !== exp_pri[x]) begin
        n_fail++;
        $display("FAIL rst_refetch x=%0d got %h/%b want %h/%b",
                 x, rd_pix[x], rd_pri[x], exp_pix[x], exp_pri[x]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scroll();
    test_flip();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
